// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V load/store initiator for a single-port data memory
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [DEPTH_LOG2-1:0] MEM_A,
  output logic [31:0]           MEM_WD,
  output logic                  MEM_WE,
  input  logic [31:0]           MEM_RD
);
  localparam int AW = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state, state_next;

  logic [AW-1:0] addr_q;
  logic [2:0]    funct3_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [31:0]   word_q;

  logic          accept;
  logic          funct3_bad, misaligned, out_of_range, req_err;
  logic [4:0]    lane_shift;
  logic [31:0]   lane_word;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [31:0]   load_val;
  logic [31:0]   merge_val;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    funct3_bad = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: funct3_bad = 1'b1;
      3'b100, 3'b101:         funct3_bad = req_we;
      default:                funct3_bad = 1'b0;
    endcase
  end

  // funct3[1:0]==01 covers both H and HU
  assign misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  assign out_of_range = |req_addr[31:AW];
  assign req_err      = funct3_bad || misaligned || out_of_range;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                            state_next = DONE;
          else if (req_we && req_funct3 == 3'b010) state_next = WR;
          else                                    state_next = RD;
        end
      end
      RD:      state_next = we_q ? WR : DONE;
      WR:      state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // MEM_WE is gated by RST_N so a reset landing in WR suppresses that edge's write
  always_comb begin
    req_ready = (state == IDLE);
    MEM_A     = '0;
    MEM_WD    = '0;
    MEM_WE    = 1'b0;
    case (state)
      RD: MEM_A = addr_q[AW-1:2];
      WR: begin
        MEM_A  = addr_q[AW-1:2];
        MEM_WD = merge_val;
        MEM_WE = RST_N;
      end
      default: ;
    endcase
  end

  assign lane_shift = {addr_q[1:0], 3'b000};
  assign lane_word  = MEM_RD >> lane_shift;
  assign lane_byte  = lane_word[7:0];
  assign lane_half  = addr_q[1] ? MEM_RD[31:16] : MEM_RD[15:0];

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{~funct3_q[2] & lane_byte[7]}}, lane_byte};
      2'b01:   load_val = {{16{~funct3_q[2] & lane_half[15]}}, lane_half};
      default: load_val = MEM_RD;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   merge_val = (word_q & ~(32'h0000_00FF << lane_shift)) |
                           ({24'h0, wdata_q[7:0]} << lane_shift);
      2'b01:   merge_val = addr_q[1] ? {wdata_q[15:0], word_q[15:0]}
                                     : {word_q[31:16], wdata_q[15:0]};
      default: merge_val = wdata_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      addr_q     <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      word_q     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr[AW-1:0];
        funct3_q <= req_funct3;
        we_q     <= req_we;
        wdata_q  <= req_wdata;
      end
      if (state == RD) word_q <= MEM_RD;
      resp_valid <= (state_next == DONE);
      resp_err   <= accept && req_err;
      resp_rdata <= (state == RD && !we_q) ? load_val : '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
// Includes a behavioural single-port memory with combinational read.
module tb_load_store_unit;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  MEM_A;
  logic [31:0] MEM_WD;
  logic        MEM_WE;
  logic [31:0] MEM_RD;

  logic [31:0] mem [0:1023];
  logic        pk_en = 1'b0;
  logic [9:0]  pk_a = '0;
  logic [31:0] pk_d = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int we_total = 0;
  int resp_total = 0;

  load_store_unit #(.DEPTH_LOG2(10)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD)
  );

  always #5 CLK = ~CLK;

  assign MEM_RD = MEM_WE ? 32'h0 : mem[MEM_A];

  always @(posedge CLK) begin
    if (MEM_WE)     mem[MEM_A] <= MEM_WD;
    else if (pk_en) mem[pk_a]  <= pk_d;
  end

  always @(negedge CLK) begin
    if (MEM_WE)     we_total++;
    if (resp_valid) resp_total++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge CLK);
    pk_en = 1'b1; pk_a = a; pk_d = d;
    @(posedge CLK); #1;
    pk_en = 1'b0;
  endtask

  task automatic do_txn(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int e_lat, input logic [31:0] e_rdata, input logic e_err,
                        input int e_wn, input int e_wcyc, input logic [31:0] e_wd);
    int lat, wn, wcyc;
    logic [31:0] rdata, wdv;
    logic [9:0] wa;
    logic err, busy_ready;
    lat = 0; wn = 0; wcyc = 0; rdata = '0; wdv = '0; wa = '0; err = 1'b0; busy_ready = 1'b1;
    @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge CLK);
      if (k == 1) busy_ready = req_ready;
      if (MEM_WE) begin wn++; wcyc = k; wa = MEM_A; wdv = MEM_WD; end
      if (resp_valid) begin lat = k; rdata = resp_rdata; err = resp_err; end
    end
    check({tag, ".lat"},   lat, e_lat);
    check({tag, ".rdata"}, rdata, e_rdata);
    check({tag, ".err"},   {31'h0, err}, {31'h0, e_err});
    check({tag, ".we_n"},  wn, e_wn);
    check({tag, ".ready"}, {31'h0, busy_ready}, 32'h0);
    if (e_wn > 0) begin
      check({tag, ".we_cyc"}, wcyc, e_wcyc);
      check({tag, ".mem_a"},  {22'h0, wa}, addr >> 2);
      check({tag, ".mem_wd"}, wdv, e_wd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, r0, nacc, nresp;
    int acc [0:2];
    logic [31:0] got [0:2];
    logic [31:0] b2b_addr [0:2];
    logic [2:0]  b2b_f3 [0:2];

    // a store held on the bus during reset must not be taken
    RST_N = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_0010; req_wdata = 32'h1234_5678;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst.resp_err",   {31'h0, resp_err},   32'h0);
    check("rst.resp_rdata", resp_rdata,          32'h0);
    check("rst.mem_we",     {31'h0, MEM_WE},     32'h0);
    check("rst.mem_a",      {22'h0, MEM_A},      32'h0);
    check("rst.mem_wd",     MEM_WD,              32'h0);
    check("rst.req_ready",  {31'h0, req_ready},  32'h1);
    RST_N = 1'b1; req_valid = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst.no_accept_we",   we_total,   0);
    check("rst.no_accept_resp", resp_total, 0);

    do_txn("sw", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 1, 1, 32'hDEAD_BEEF);
    check("sw.mem", mem[4], 32'hDEAD_BEEF);

    poke(10'd4, 32'h8070_F0FF);
    do_txn("lb",  1'b0, 3'b000, 32'h11, 32'h0, 2, 32'hFFFF_FFF0, 1'b0, 0, 0, 32'h0);
    do_txn("lbu", 1'b0, 3'b100, 32'h11, 32'h0, 2, 32'h0000_00F0, 1'b0, 0, 0, 32'h0);
    do_txn("lh",  1'b0, 3'b001, 32'h12, 32'h0, 2, 32'hFFFF_8070, 1'b0, 0, 0, 32'h0);
    do_txn("lhu", 1'b0, 3'b101, 32'h12, 32'h0, 2, 32'h0000_8070, 1'b0, 0, 0, 32'h0);
    do_txn("lw",  1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h8070_F0FF, 1'b0, 0, 0, 32'h0);
    do_txn("lb0", 1'b0, 3'b000, 32'h10, 32'h0, 2, 32'hFFFF_FFFF, 1'b0, 0, 0, 32'h0);

    poke(10'd4, 32'h1122_3344);
    do_txn("sb", 1'b1, 3'b000, 32'h12, 32'h0000_00AB, 3, 32'h0, 1'b0, 1, 2, 32'h11AB_3344);
    check("sb.mem", mem[4], 32'h11AB_3344);
    do_txn("sh", 1'b1, 3'b001, 32'h10, 32'h0000_CAFE, 3, 32'h0, 1'b0, 1, 2, 32'h11AB_CAFE);
    check("sh.mem", mem[4], 32'h11AB_CAFE);

    do_txn("err_lw_mis",  1'b0, 3'b010, 32'h13,   32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0);
    do_txn("err_sh_mis",  1'b1, 3'b001, 32'h21,   32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0);
    do_txn("err_f3_st",   1'b1, 3'b100, 32'h10,   32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0);
    do_txn("err_range",   1'b0, 3'b010, 32'h1000, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0);
    do_txn("err_f3_011",  1'b0, 3'b011, 32'h10,   32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0);
    check("err.mem", mem[4], 32'h11AB_CAFE);

    // reset landing in RD of an SB
    poke(10'd5, 32'h5566_7788);
    w0 = we_total; r0 = resp_total;
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h14; req_wdata = 32'h99;
    @(posedge CLK); #1;
    req_valid = 1'b0; RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_rd.ready", {31'h0, req_ready}, 32'h1);
    repeat (3) @(negedge CLK);
    check("rst_rd.we",   we_total - w0,   0);
    check("rst_rd.resp", resp_total - r0, 0);
    check("rst_rd.mem",  mem[5], 32'h5566_7788);

    // reset landing in WR of an SB
    w0 = we_total; r0 = resp_total;
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h15; req_wdata = 32'h99;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_wr.ready", {31'h0, req_ready}, 32'h1);
    repeat (3) @(negedge CLK);
    check("rst_wr.we",   we_total - w0,   0);
    check("rst_wr.resp", resp_total - r0, 0);
    check("rst_wr.mem",  mem[5], 32'h5566_7788);

    // back-to-back loads with req_valid held high
    poke(10'd8,  32'h0000_00A5);
    poke(10'd9,  32'h1234_5678);
    poke(10'd10, 32'hCAFE_F00D);
    b2b_addr[0] = 32'h20; b2b_f3[0] = 3'b100;
    b2b_addr[1] = 32'h26; b2b_f3[1] = 3'b101;
    b2b_addr[2] = 32'h28; b2b_f3[2] = 3'b010;
    nacc = 0; nresp = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    got[0] = '0; got[1] = '0; got[2] = '0;
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_wdata = 32'h0;
    req_addr = b2b_addr[0]; req_funct3 = b2b_f3[0];
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge CLK);
      if (resp_valid) begin
        if (nresp < 3) got[nresp] = resp_rdata;
        nresp++;
      end
      if (req_ready && nacc < 3) begin
        acc[nacc] = c;
        nacc++;
        @(posedge CLK); #1;
        if (nacc < 3) begin
          req_addr = b2b_addr[nacc]; req_funct3 = b2b_f3[nacc];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    check("b2b.n_accept", nacc, 3);
    check("b2b.n_resp",   nresp, 3);
    check("b2b.gap01",    acc[1] - acc[0], 3);
    check("b2b.gap12",    acc[2] - acc[1], 3);
    check("b2b.rdata0",   got[0], 32'h0000_00A5);
    check("b2b.rdata1",   got[1], 32'h0000_1234);
    check("b2b.rdata2",   got[2], 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the single-port data memory. It accepts one RISC-V load or store per handshake and drives the memory's word address, write data and write enable. Stores narrower than a word are built as a read-modify-write. Load results are byte-lane extracted and sign- or zero-extended. It sits between the execute stage and the data memory, which has a combinational read, a synchronous write, and RD forced to 0 while WE=1.

## Interface
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words; the valid byte-address range is 0 .. 4*2^DEPTH_LOG2-1.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high exactly when state is IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or half is used for B/H.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  completion with error; no memory write occurred.
- MEM_A  out  DEPTH_LOG2  word index, equal to latched addr[DEPTH_LOG2+1:2] in RD/WR, else 0.
- MEM_WD  out  32  write data in WR, else 0.
- MEM_WE  out  1  high only in WR.
- MEM_RD  in  32  combinational read data from memory.

## Operation
- **FSM states:** IDLE, RD, WR, DONE. Reset value is IDLE.
- **Handshake:** a request is accepted at a rising edge where req_valid && req_ready. On acceptance, addr, funct3, we and wdata are latched. Inputs are ignored at all other times.
- **Error check at acceptance (any one gives an error):**
  - illegal funct3: 011, 110 or 111, or 100/101 with we=1;
  - H access with addr[0]=1;
  - W access with addr[1:0]≠0;
  - addr ≥ 4*2^DEPTH_LOG2.
- **Error path:** IDLE→DONE with the error flag set. The memory is never touched.
- **Transitions:**
  - Load: IDLE→RD→DONE.
  - SW: IDLE→WR→DONE.
  - SB/SH: IDLE→RD→WR→DONE.
  - DONE→IDLE always.
- **RD:** MEM_WE=0. At the closing edge, MEM_RD is captured into a word register.
- **Load extraction (little-endian):**
  - Byte lane = addr[1:0]; half = addr[1]?[31:16]:[15:0].
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word unchanged.
- **Store merge:** SB replaces byte lane addr[1:0] of the captured word with wdata[7:0]. SH replaces the half with wdata[15:0]. The other bytes are unchanged. SW writes wdata directly.
- **DONE:**
  - resp_valid=1 for one cycle.
  - resp_rdata holds the extracted value for a successful load, else 0.
  - resp_err holds the error flag.
- **Reset (RST_N low at an edge):**
  - Forces IDLE and clears the captured word, flags and latched request.
  - The next cycle has MEM_WE=0, resp_valid=0, resp_err=0, resp_rdata=0, MEM_A=0, MEM_WD=0.
  - Reset during RD aborts an SB/SH with no write.
  - Reset during WR deasserts MEM_WE from the next cycle; the write at that edge does not occur.
  - No response is produced for the aborted request.
- **Requests while RST_N is low:** not accepted, even though IDLE drives req_ready=1.

## Timing
- Define N as the cycle whose closing edge accepts the request.
- Load: RD in N+1, resp_valid in N+2. Latency 2.
- SW: WR in N+1, with the memory write at the edge closing N+1. resp_valid in N+2.
- SB/SH: RD in N+1, WR in N+2, resp_valid in N+3.
- Error: resp_valid and resp_err in N+1.
- req_ready is low from N+1 until DONE completes. The next request can be accepted at the edge closing the first IDLE cycle after DONE.
- Throughput: one load every 3 cycles, one SB/SH every 4 cycles.
- All outputs except req_ready, MEM_A, MEM_WD and MEM_WE come from registers. Those four decode from registered state and latched fields only; there is no combinational path from req_* to any output.

## Test plan
- Reset, then SW addr 0x10, data 0xDEADBEEF. MEM_WE high one cycle with MEM_A=4 and MEM_WD=0xDEADBEEF. resp_valid 2 cycles after accept, rdata 0, err 0.
- Memory word 4 = 0x8070F0FF:
  - LB addr 0x11 → 0xFFFFFFF0.
  - LBU 0x11 → 0x000000F0.
  - LH 0x12 → 0xFFFF8070.
  - LHU 0x12 → 0x00008070.
  - LW 0x10 → 0x8070F0FF.
  - Each response 2 cycles after accept, with MEM_WE never high.
- Word 4 = 0x11223344. SB addr 0x12, data 0xAB → WR writes 0x11AB3344 on cycle N+2. SH 0x10, data 0xCAFE → 0x11ABCAFE. resp_valid at N+3.
- Each error case gives resp_err=1, resp_valid at N+1 and no MEM_WE pulse:
  - LW 0x13;
  - SH 0x21;
  - funct3 100 with we=1;
  - LW 0x1000 (DEPTH_LOG2=10).
- Start SB and pull RST_N low during RD. No MEM_WE pulse, no resp_valid, and req_ready=1 the cycle after reset releases. Repeat with the reset landing in WR and check that the memory word is unchanged.
- Back-to-back: req_valid held high with three queued loads. They are accepted every 3 cycles, and a request held while req_ready=0 is not double-accepted.
